// File: rtl/serial_tx_arbiter.sv
// Round-robin, message-locked sharing of one UART transmitter among NUM_REQ byte streams.
// Optional idle-release timeout inside a locked message: `define SERIAL_TX_ARB_TIMEOUT_EN.
module serial_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLK,
  input  logic                   IN_PB_RESET,
  input  logic [NUM_REQ-1:0]     IN_REQ_VALID,
  input  logic [8*NUM_REQ-1:0]   IN_REQ_DATA,
  input  logic [NUM_REQ-1:0]     IN_REQ_LAST,
  output logic [NUM_REQ-1:0]     OUT_REQ_READY,
  output logic [7:0]             OUT_TX_DATA,
  output logic                   OUT_TX_START,
  input  logic                   IN_TX_BUSY,
  output logic [NUM_REQ-1:0]     OUT_GRANT,
  output logic                   OUT_TIMEOUT
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WACK  = 2'd2;
  localparam logic [1:0] S_WDONE = 2'd3;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("serial_tx_arbiter: unsupported parameters");
  end

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [7:0]         data_q, data_d;
  logic               start_q, start_d;
  logic               last_q, last_d;
  logic               tmo_q, tmo_d;

  logic               valid_g;
  logic [7:0]         byte_g;
  logic [IW-1:0]      pick;
  logic [IW-1:0]      nxt;
  logic               to_fire;

  assign valid_g = IN_REQ_VALID[gidx_q];
  assign byte_g  = IN_REQ_DATA[{gidx_q, 3'b000} +: 8];
  assign nxt     = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

  // Walk offsets from far to near so the one closest to ptr wins.
  always_comb begin
    pick = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (IN_REQ_VALID[IW'((int'(ptr_q) + i) % NUM_REQ)])
        pick = IW'((int'(ptr_q) + i) % NUM_REQ);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    data_d  = data_q;
    last_d  = last_q;
    ready_d = '0;
    start_d = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|IN_REQ_VALID) begin
          gidx_d  = pick;
          grant_d = NUM_REQ'(1) << pick;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (valid_g && !IN_TX_BUSY) begin
          data_d  = byte_g;
          last_d  = IN_REQ_LAST[gidx_q];
          start_d = 1'b1;
          ready_d = grant_q;
          state_d = S_WACK;
        end else if (to_fire) begin
          grant_d = '0;
          ptr_d   = nxt;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WACK: begin
        if (IN_TX_BUSY) state_d = S_WDONE;
      end
      S_WDONE: begin
        if (!IN_TX_BUSY) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = nxt;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic          sent_q, sent_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Idle cycles only count once the message has put a byte on the wire.
  always_comb begin
    sent_d  = sent_q;
    cnt_d   = cnt_q;
    to_fire = 1'b0;
    if (state_q == S_IDLE) begin
      sent_d = 1'b0;
      cnt_d  = '0;
    end else if (state_q == S_LOAD) begin
      if (valid_g) begin
        cnt_d = '0;
        if (!IN_TX_BUSY) sent_d = 1'b1;
      end else if (sent_q) begin
        if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          to_fire = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      sent_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sent_q <= sent_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      ready_q <= '0;
      data_q  <= 8'h00;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      start_q <= start_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  assign OUT_REQ_READY = ready_q;
  assign OUT_TX_DATA   = data_q;
  assign OUT_TX_START  = start_q;
  assign OUT_GRANT     = grant_q;
  assign OUT_TIMEOUT   = tmo_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: per-requester byte scoreboard, grant-order
// table, and hand sequences for reset, locking, back-to-back and timeout.
module tb_serial_tx_arbiter;

  localparam int N     = 4;
  localparam int FRAME = 10;

  logic           CLK   = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   vld   = '0;
  logic [8*N-1:0] dat   = '0;
  logic [N-1:0]   lst   = '0;
  logic [N-1:0]   rdy;
  logic [7:0]     txd;
  logic           txs;
  logic           busy  = 1'b0;
  logic [N-1:0]   gnt;
  logic           tmo;

  always #5 CLK = ~CLK;

  serial_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK),
    .IN_PB_RESET(rst_n),
    .IN_REQ_VALID(vld),
    .IN_REQ_DATA(dat),
    .IN_REQ_LAST(lst),
    .OUT_REQ_READY(rdy),
    .OUT_TX_DATA(txd),
    .OUT_TX_START(txs),
    .IN_TX_BUSY(busy),
    .OUT_GRANT(gnt),
    .OUT_TIMEOUT(tmo)
  );

  logic [8:0] rq   [N][$];
  logic [7:0] expq [N][$];
  int         grant_log[$];
  int         total = 0;
  int         bad = 0;
  int         starts = 0;
  int         tmo_cnt = 0;
  int         rdy_cnt [N];
  int         ucnt = 0;
  logic [N-1:0] prev_g = '0;

  typedef struct {
    logic [3:0] mask;
    int         n;
    logic [7:0] ord;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int oh2i(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit reqs_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // UART model: busy for FRAME cycles after each start strobe
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      ucnt <= 0;
    end else if (ucnt != 0) begin
      ucnt <= ucnt - 1;
      if (ucnt == 1) busy <= 1'b0;
    end else if (txs) begin
      busy <= 1'b1;
      ucnt <= FRAME;
    end
  end

  // requesters: present queue head, advance on READY
  always @(posedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        vld[i]       <= 1'b1;
        dat[8*i +: 8] <= rq[i][0][7:0];
        lst[i]       <= rq[i][0][8];
      end else begin
        vld[i]       <= 1'b0;
        dat[8*i +: 8] <= 8'h00;
        lst[i]       <= 1'b0;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge CLK) begin
    int idx;
    if (!rst_n) begin
      prev_g = '0;
    end else begin
      if (txs || rdy != '0) begin
        chk("ready_eq_grant", 32'(rdy), 32'(gnt));
        chk("start_with_ready", 32'(txs), 32'd1);
        idx = oh2i(gnt);
        if (!$onehot(gnt)) begin
          chk("grant_onehot_at_start", 32'(gnt), 32'd0);
        end else if (expq[idx].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: req %0d sent %0h, none expected", idx, txd);
        end else begin
          chk($sformatf("tx_data_req%0d", idx), 32'(txd), 32'(expq[idx].pop_front()));
        end
      end
      for (int i = 0; i < N; i++) if (rdy[i]) rdy_cnt[i]++;
      if (txs) starts++;
      if (tmo) tmo_cnt++;
      if (gnt != prev_g) begin
        chk("grant_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (gnt != '0) grant_log.push_back(oh2i(gnt));
      end
      prev_g = gnt;
    end
  end

  task automatic push(int r, logic [7:0] b, logic l);
    rq[r].push_back({l, b});
    expq[r].push_back(b);
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (k < budget && !(reqs_empty() && gnt == '0 && !busy && !txs)) begin
      @(negedge CLK);
      k++;
    end
    if (k >= budget) begin
      total++;
      bad++;
      $display("FAIL wait_idle: bound %0d cycles expired", budget);
    end
  endtask

  task automatic wait_for(bit on_busy, int budget);
    int k = 0;
    while (k < budget && !(on_busy ? busy : txs)) begin
      @(negedge CLK);
      k++;
    end
    if (k >= budget) begin
      total++;
      bad++;
      $display("FAIL wait_for: %s not seen in %0d cycles", on_busy ? "busy" : "start", budget);
    end
  endtask

  task automatic chk_order(string nm, int n, logic [7:0] ord);
    chk({nm, "_count"}, 32'(grant_log.size()), 32'(n));
    for (int k = 0; k < n && k < grant_log.size(); k++)
      chk($sformatf("%s_grant%0d", nm, k), 32'(grant_log[k]), 32'(ord[2*k +: 2]));
  endtask

  initial begin
    int s0, r0, t0;
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;

    tbl[0] = '{4'b1111, 4, {2'd2, 2'd1, 2'd0, 2'd3}};
    tbl[1] = '{4'b0110, 2, {4'd0, 2'd2, 2'd1}};
    tbl[2] = '{4'b1000, 1, {6'd0, 2'd3}};
    tbl[3] = '{4'b1001, 2, {4'd0, 2'd3, 2'd0}};
    tbl[4] = '{4'b0011, 2, {4'd0, 2'd1, 2'd0}};
    tbl[5] = '{4'b1101, 3, {2'd0, 2'd0, 2'd3, 2'd2}};
    tbl[6] = '{4'b0101, 2, {4'd0, 2'd0, 2'd2}};
    tbl[7] = '{4'b1010, 2, {4'd0, 2'd3, 2'd1}};

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_grant", 32'(gnt), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_txdata", 32'(txd), 32'd0);
    chk("rst_start", 32'(txs), 32'd0);
    chk("rst_timeout", 32'(tmo), 32'd0);
    rst_n = 1'b1;
    @(negedge CLK);

    // req1 sends "OK\n"
    grant_log.delete();
    s0 = starts;
    r0 = rdy_cnt[1];
    push(1, 8'h4F, 1'b0);
    push(1, 8'h4B, 1'b0);
    push(1, 8'h0A, 1'b1);
    wait_idle(2000);
    chk("ok_starts", 32'(starts - s0), 32'd3);
    chk("ok_ready1", 32'(rdy_cnt[1] - r0), 32'd3);
    chk_order("ok", 1, 8'h01);
    chk("ok_grant_released", 32'(gnt), 32'd0);

    // reset in the middle of a frame
    r0 = rdy_cnt[2];
    push(2, 8'h11, 1'b0);
    push(2, 8'h22, 1'b1);
    wait_for(1'b1, 200);
    repeat (3) @(negedge CLK);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      expq[i].delete();
    end
    #1;
    chk("midrst_grant", 32'(gnt), 32'd0);
    chk("midrst_ready", 32'(rdy), 32'd0);
    chk("midrst_txdata", 32'(txd), 32'd0);
    chk("midrst_start", 32'(txs), 32'd0);
    chk("midrst_timeout", 32'(tmo), 32'd0);
    chk("midrst_ready2", 32'(rdy_cnt[2] - r0), 32'd1);
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);

    // req0 and req2 together after reset: pointer restarts at 0
    grant_log.delete();
    push(0, 8'hA0, 1'b1);
    push(2, 8'hA2, 1'b1);
    wait_idle(2000);
    chk_order("post_reset", 2, {4'd0, 2'd2, 2'd0});

    // round-robin table
    for (int t = 0; t < 8; t++) begin
      grant_log.delete();
      for (int i = 0; i < N; i++)
        if (tbl[t].mask[i]) push(i, 8'(8'h40 + 16 * t + i), 1'b1);
      wait_idle(2000);
      chk_order($sformatf("tbl%0d", t), tbl[t].n, tbl[t].ord);
    end

    // req0 held off while req3 owns the lock
    grant_log.delete();
    s0 = rdy_cnt[0];
    r0 = rdy_cnt[3];
    push(3, 8'h31, 1'b0);
    push(3, 8'h32, 1'b0);
    push(3, 8'h33, 1'b1);
    wait_for(1'b0, 200);
    push(0, 8'h01, 1'b1);
    wait_idle(3000);
    chk_order("lock", 2, {4'd0, 2'd0, 2'd3});
    chk("lock_ready3", 32'(rdy_cnt[3] - r0), 32'd3);
    chk("lock_ready0", 32'(rdy_cnt[0] - s0), 32'd1);

    // back-to-back single-byte messages alternate with a waiting requester
    grant_log.delete();
    push(1, 8'hB1, 1'b1);
    push(1, 8'hB2, 1'b1);
    push(1, 8'hB3, 1'b1);
    push(2, 8'hC1, 1'b1);
    push(2, 8'hC2, 1'b1);
    wait_idle(3000);
    chk("b2b_count", 32'(grant_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      chk($sformatf("b2b_grant%0d", k), 32'(grant_log[k]), (k % 2 == 0) ? 32'd1 : 32'd2);

    // owner goes quiet after one non-LAST byte
    grant_log.delete();
    t0 = tmo_cnt;
    push(2, 8'h55, 1'b0);
    wait_for(1'b1, 200);
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
    repeat (60) @(negedge CLK);
    chk("tmo_pulses", 32'(tmo_cnt - t0), 32'd1);
    chk("tmo_grant", 32'(gnt), 32'd0);
`else
    repeat (1000) @(negedge CLK);
    chk("hold_grant", 32'(gnt), 32'b0100);
    chk("hold_no_timeout", 32'(tmo_cnt - t0), 32'd0);
`endif
    push(2, 8'h66, 1'b1);
    wait_idle(2000);
    chk("final_grant", 32'(gnt), 32'd0);
    s0 = 0;
    for (int i = 0; i < N; i++) s0 += expq[i].size();
    chk("scoreboard_drained", 32'(s0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
